// File: rtl/rem_denorm.sv
// rem_denorm: iterative remainder denormalizer for the radix-16 divider.
// Takes the left-normalized remainder and the normalization count, shifts
// the remainder back right by at most SHIFT_PER_CYCLE bits per cycle,
// optionally negates it, and holds the result until writeback accepts it.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; start_ready_o high
// SHIFT | undoing normalization, up to SHIFT_PER_CYCLE bits per cycle
// NEG   | one-cycle two's-complement sign restore
// DONE  | result on rem_o, finish_valid_o high until finish_ready_i

module rem_denorm #(
    parameter int WIDTH           = 64,
    parameter int CNT_WIDTH       = $clog2(WIDTH),
    parameter int SHIFT_PER_CYCLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 start_valid_i,
    output logic                 start_ready_o,
    input  logic [WIDTH-1:0]     rem_norm_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 neg_i,
    output logic                 finish_valid_o,
    input  logic                 finish_ready_i,
    output logic [WIDTH-1:0]     rem_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        NEG   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One extra bit so SHIFT_PER_CYCLE == WIDTH is still representable.
    localparam logic [CNT_WIDTH:0] SPC     = (CNT_WIDTH+1)'(SHIFT_PER_CYCLE);
    localparam logic [CNT_WIDTH:0] CNT_LIM = (CNT_WIDTH+1)'(WIDTH);
    localparam logic [WIDTH-1:0]   ONE     = WIDTH'(1);

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     rem_q;
    logic [CNT_WIDTH-1:0] remaining_q;
    logic                 neg_q;

    logic                 accept;
    logic [CNT_WIDTH-1:0] step;
    logic [CNT_WIDTH-1:0] remaining_nxt;

    // Flush wins over a simultaneous request.
    assign accept = start_valid_i && (state_q == IDLE) && !flush_i;

    // Shift amount for this cycle: min(remaining, SHIFT_PER_CYCLE).
    always_comb begin
        step = remaining_q;
        if ({1'b0, remaining_q} > SPC) begin
            step = SPC[CNT_WIDTH-1:0];
        end
        remaining_nxt = remaining_q - step;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; flush forces IDLE from any state.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_valid_i) begin
                        if (cnt_i != '0) begin
                            state_d = SHIFT;
                        end else if (neg_i) begin
                            state_d = NEG;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (remaining_nxt == '0) begin
                        state_d = neg_q ? NEG : DONE;
                    end
                end
                NEG: begin
                    state_d = DONE;
                end
                DONE: begin
                    if (finish_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Datapath: load on accept, shift in SHIFT, negate in NEG. A flush
    // freezes rem/remaining rather than clearing them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q       <= '0;
            remaining_q <= '0;
            neg_q       <= 1'b0;
        end else if (!flush_i) begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        rem_q       <= rem_norm_i;
                        remaining_q <= cnt_i;
                        neg_q       <= neg_i;
                    end
                end
                SHIFT: begin
                    rem_q       <= rem_q >> step;
                    remaining_q <= remaining_nxt;
                end
                NEG: begin
                    rem_q <= (~rem_q) + ONE;
                end
                DONE: begin
                    rem_q <= rem_q;
                end
                default: begin
                    rem_q <= rem_q;
                end
            endcase
        end
    end

    // Output decode: purely from registered state, no input-to-output path.
    always_comb begin
        start_ready_o  = (state_q == IDLE);
        finish_valid_o = (state_q == DONE);
    end

    assign rem_o = rem_q;

`ifndef SYNTHESIS
    // Shift counts of WIDTH or more cannot come from a valid normalization.
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        accept |-> ({1'b0, cnt_i} < CNT_LIM));
`endif

endmodule

// File: tb/tb_rem_denorm.sv
// tb_rem_denorm: randomized and directed checks of rem_denorm against a
// plain arithmetic model (result = +/-(rem >> cnt), latency from cnt/neg).

module tb_rem_denorm;

    localparam int W   = 64;
    localparam int CW  = $clog2(W);
    localparam int SPC = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_i = 1'b0;
    logic          start_valid_i = 1'b0;
    logic          start_ready_o;
    logic [W-1:0]  rem_norm_i = '0;
    logic [CW-1:0] cnt_i = '0;
    logic          neg_i = 1'b0;
    logic          finish_valid_o;
    logic          finish_ready_i = 1'b0;
    logic [W-1:0]  rem_o;

    int n_pass = 0;
    int n_total = 0;

    rem_denorm #(.WIDTH(W), .SHIFT_PER_CYCLE(SPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .start_valid_i  (start_valid_i),
        .start_ready_o  (start_ready_o),
        .rem_norm_i     (rem_norm_i),
        .cnt_i          (cnt_i),
        .neg_i          (neg_i),
        .finish_valid_o (finish_valid_o),
        .finish_ready_i (finish_ready_i),
        .rem_o          (rem_o)
    );

    always #5 clk = ~clk;

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] model_rem(input logic [W-1:0] r, input int cnt, input bit neg);
        logic [W-1:0] v;
        v = r >> cnt;
        if (neg) v = W'(0) - v;
        return v;
    endfunction

    function automatic int model_lat(input int cnt, input bit neg);
        return 1 + (cnt + SPC - 1) / SPC + (neg ? 1 : 0);
    endfunction

    // One full transaction: request, wait for result, optional backpressure,
    // handshake. Leaves the bench one cycle after the handshake (IDLE).
    task automatic do_op(input string nm, input logic [W-1:0] r, input int cnt,
                         input bit neg, input int hold);
        logic [W-1:0] exp_rem;
        logic [W-1:0] held;
        int exp_lat;
        int k;
        exp_rem = model_rem(r, cnt, neg);
        exp_lat = model_lat(cnt, neg);

        n_total++;
        if (start_ready_o !== 1'b1) $display("FAIL %s ready_before_start got=%b exp=1", nm, start_ready_o);
        else n_pass++;

        start_valid_i = 1'b1;
        rem_norm_i    = r;
        cnt_i         = CW'(cnt);
        neg_i         = neg;
        step_cycle();
        start_valid_i = 1'b0;
        rem_norm_i    = {$urandom, $urandom};
        cnt_i         = CW'($urandom);
        neg_i         = 1'($urandom);

        k = 1;
        while (finish_valid_o !== 1'b1 && k < 20) begin
            step_cycle();
            k++;
        end
        n_total++;
        if (k !== exp_lat) $display("FAIL %s latency got=%0d exp=%0d", nm, k, exp_lat);
        else n_pass++;
        n_total++;
        if (rem_o !== exp_rem) $display("FAIL %s rem got=%h exp=%h", nm, rem_o, exp_rem);
        else n_pass++;

        held = rem_o;
        for (int i = 0; i < hold; i++) begin
            step_cycle();
            n_total++;
            if (rem_o !== held || finish_valid_o !== 1'b1 || start_ready_o !== 1'b0)
                $display("FAIL %s hold rem=%h valid=%b ready=%b exp rem=%h valid=1 ready=0",
                         nm, rem_o, finish_valid_o, start_ready_o, held);
            else n_pass++;
        end

        finish_ready_i = 1'b1;
        step_cycle();
        finish_ready_i = 1'b0;
        n_total++;
        if (start_ready_o !== 1'b1 || finish_valid_o !== 1'b0)
            $display("FAIL %s after_handshake ready=%b valid=%b exp ready=1 valid=0",
                     nm, start_ready_o, finish_valid_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_total++;
        if (start_ready_o !== 1'b1 || finish_valid_o !== 1'b0 || rem_o !== '0)
            $display("FAIL reset ready=%b valid=%b rem=%h exp ready=1 valid=0 rem=0",
                     start_ready_o, finish_valid_o, rem_o);
        else n_pass++;
        rst = 1'b0;
        step_cycle();
    endtask

    task automatic test_directed();
        do_op("t1_cnt63", 64'h8000_0000_0000_0000, 63, 1'b0, 0);
        n_total++;
        if (model_rem(64'h8000_0000_0000_0000, 63, 1'b0) !== 64'h1 || model_lat(63, 1'b0) !== 5)
            $display("FAIL model_t1 rem=%h lat=%0d exp rem=1 lat=5",
                     model_rem(64'h8000_0000_0000_0000, 63, 1'b0), model_lat(63, 1'b0));
        else n_pass++;
        do_op("t2_cnt0",     64'h1234, 0, 1'b0, 0);
        do_op("t2_cnt0_neg", 64'h1234, 0, 1'b1, 0);
        do_op("t3_neg",      64'h50,   4, 1'b1, 0);
        do_op("t3_zero_neg", 64'h0,    5, 1'b1, 0);
        do_op("cnt16",       {$urandom, $urandom}, 16, 1'b0, 0);
        do_op("cnt17_neg",   {$urandom, $urandom}, 17, 1'b1, 1);
    endtask

    task automatic test_backpressure();
        do_op("bp_hold3", 64'h8000_0000_0000_0000, 63, 1'b0, 3);
        do_op("bp_b2b",   64'hDEAD_BEEF_0000_1234, 12, 1'b1, 0);
    endtask

    task automatic test_flush();
        int seen;
        start_valid_i = 1'b1;
        rem_norm_i    = 64'hFFFF_0000_FFFF_0000;
        cnt_i         = CW'(48);
        neg_i         = 1'b0;
        step_cycle();
        start_valid_i = 1'b0;
        step_cycle();
        flush_i = 1'b1;
        step_cycle();
        flush_i = 1'b0;
        n_total++;
        if (start_ready_o !== 1'b1 || finish_valid_o !== 1'b0)
            $display("FAIL flush_shift ready=%b valid=%b exp ready=1 valid=0", start_ready_o, finish_valid_o);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (finish_valid_o === 1'b1) seen++;
            step_cycle();
        end
        n_total++;
        if (seen !== 0) $display("FAIL flush_no_valid got=%0d exp=0", seen);
        else n_pass++;

        do_op("after_flush", 64'hF0, 4, 1'b0, 0);

        start_valid_i = 1'b1;
        rem_norm_i    = 64'h1;
        cnt_i         = '0;
        neg_i         = 1'b0;
        flush_i       = 1'b1;
        step_cycle();
        start_valid_i = 1'b0;
        flush_i       = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (finish_valid_o === 1'b1 || start_ready_o !== 1'b1) seen++;
            step_cycle();
        end
        n_total++;
        if (seen !== 0) $display("FAIL flush_idle_accepted got=%0d bad cycles exp=0", seen);
        else n_pass++;

        // Flush together with the DONE handshake: exactly one result.
        start_valid_i = 1'b1;
        rem_norm_i    = 64'h77;
        cnt_i         = '0;
        neg_i         = 1'b0;
        step_cycle();
        start_valid_i = 1'b0;
        n_total++;
        if (finish_valid_o !== 1'b1 || rem_o !== 64'h77)
            $display("FAIL flush_done_pre valid=%b rem=%h exp valid=1 rem=77", finish_valid_o, rem_o);
        else n_pass++;
        flush_i        = 1'b1;
        finish_ready_i = 1'b1;
        step_cycle();
        flush_i        = 1'b0;
        finish_ready_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (finish_valid_o === 1'b1 || start_ready_o !== 1'b1) seen++;
            step_cycle();
        end
        n_total++;
        if (seen !== 0) $display("FAIL flush_done_second got=%0d bad cycles exp=0", seen);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        start_valid_i = 1'b1;
        rem_norm_i    = 64'h8000_0000_0000_0000;
        cnt_i         = CW'(63);
        neg_i         = 1'b0;
        step_cycle();
        start_valid_i = 1'b0;
        step_cycle();
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (start_ready_o !== 1'b1 || finish_valid_o !== 1'b0 || rem_o !== '0)
            $display("FAIL async_reset ready=%b valid=%b rem=%h exp ready=1 valid=0 rem=0",
                     start_ready_o, finish_valid_o, rem_o);
        else n_pass++;
        #1 rst = 1'b0;
        step_cycle();
        do_op("post_reset_t1", 64'h8000_0000_0000_0000, 63, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [W-1:0] r;
        for (int i = 0; i < 40; i++) begin
            r = {$urandom, $urandom};
            do_op($sformatf("rand%0d", i), r, $urandom_range(0, W-1), 1'($urandom),
                  $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rem_denorm.md
Name: rem_denorm

Overview:
- Iterative remainder denormalizer for the radix-16 integer divider.
- The divider left-normalizes the divisor by its leading-zero count before iterating, so the final remainder comes out scaled by that same count. This block consumes the normalized remainder and the count, and undoes the scaling with a multi-cycle right shift.
- Optionally restores sign with a two's-complement step, then holds the result until the divider's writeback accepts it.
- Sits between the divider iteration core and the result mux.

Parameters:
- WIDTH, 64: remainder width in bits; must be ≥2.
- CNT_WIDTH, $clog2(WIDTH): width of the shift count. Derived; do not override.
- SHIFT_PER_CYCLE, 16: maximum right shift per SHIFT cycle. Power of two, 1 ≤ SHIFT_PER_CYCLE ≤ WIDTH.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- flush_i  in  1  kill the in-flight operation.
- start_valid_i  in  1  request valid.
- start_ready_o  out  1  block can accept a request.
- rem_norm_i  in  WIDTH  normalized remainder, unsigned magnitude.
- cnt_i  in  CNT_WIDTH  right-shift amount, 0..WIDTH-1.
- neg_i  in  1  result must be negated (dividend was negative).
- finish_valid_o  out  1  rem_o is valid.
- finish_ready_i  in  1  consumer accepts rem_o.
- rem_o  out  WIDTH  denormalized (and sign-restored) remainder.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state=IDLE, rem register=0, remaining-count register=0, neg register=0.
  - Outputs: start_ready_o=1, finish_valid_o=0, rem_o=0.
- States: IDLE, SHIFT, NEG, DONE. One-hot or binary encoding is allowed.
- Output decode:
  - start_ready_o = (state==IDLE).
  - finish_valid_o = (state==DONE).
  - rem_o = rem register in every state. It is meaningful only in DONE.
- IDLE:
  - Acceptance occurs on an edge where start_valid_i=1 and start_ready_o=1.
  - On acceptance, load rem=rem_norm_i, remaining=cnt_i, neg=neg_i.
  - Next state: SHIFT if cnt_i≠0; else NEG if neg_i=1; else DONE.
- SHIFT, each cycle:
  - s = min(remaining, SHIFT_PER_CYCLE).
  - rem <= rem >> s (logical, zero-fill).
  - remaining <= remaining - s.
  - If remaining - s == 0, go to NEG when neg=1, otherwise DONE. Otherwise stay in SHIFT.
  - Number of SHIFT cycles = ceil(cnt_i / SHIFT_PER_CYCLE).
- NEG (one cycle): rem <= ~rem + 1, truncated to WIDTH bits, then go to DONE. Negating 0 yields 0.
- DONE:
  - rem_o is held stable while finish_ready_i=0.
  - On finish_ready_i=1, go to IDLE.
  - No new request is accepted in the DONE cycle; start_ready_o rises the cycle after the handshake.
- Latency: request accepted at the edge ending cycle T → finish_valid_o=1 in cycle T + 1 + ceil(cnt_i/SHIFT_PER_CYCLE) + neg_i.
- Inputs are sampled only at acceptance. Changes to rem_norm_i, cnt_i or neg_i afterwards have no effect.
- flush_i=1 at an edge:
  - Next state is IDLE regardless of current state, so finish_valid_o=0 in the next cycle.
  - rem and remaining are not cleared.
  - flush_i has priority over acceptance: a request presented in IDLE with flush_i=1 is not accepted.
  - flush_i during DONE together with finish_ready_i=1 → IDLE, and no second output is produced.
- cnt_i values ≥ WIDTH are illegal. With SVA enabled, assert on acceptance. Behaviour is otherwise unspecified.
- No combinational path from any input to any output.

Test Plan (WIDTH=64, SHIFT_PER_CYCLE=16):
1. rem_norm_i=0x8000_0000_0000_0000, cnt_i=63, neg_i=0, accepted at T → SHIFT for 4 cycles (16,16,16,15); finish_valid_o=1 at T+5 with rem_o=0x0000_0000_0000_0001.
2. rem_norm_i=0x1234, cnt_i=0, neg_i=0 → finish_valid_o=1 at T+1, rem_o=0x1234; with neg_i=1 instead → T+2, rem_o=0xFFFF_FFFF_FFFF_EDCC.
3. rem_norm_i=0x50, cnt_i=4, neg_i=1 → finish_valid_o=1 at T+3 with rem_o=0xFFFF_FFFF_FFFF_FFFB; rem_norm_i=0, cnt_i=5, neg_i=1 → rem_o=0.
4. Backpressure: test 1 with finish_ready_i=0 for 3 cycles after finish_valid_o rises → rem_o constant, start_ready_o=0 throughout; handshake in cycle D → start_ready_o=1 in D+1, and a back-to-back request accepted in D+1 completes correctly.
5. flush_i=1 in the 2nd SHIFT cycle of cnt_i=48 → IDLE next cycle, finish_valid_o never asserts; next request (0xF0, cnt_i=4, neg_i=0) yields rem_o=0xF at T+2; flush_i with start_valid_i in IDLE → request not accepted.
6. rst pulsed asynchronously (between clock edges) mid-SHIFT → finish_valid_o=0, start_ready_o=1, rem_o=0 immediately; after release, test 1 repeats with identical timing.
